// File: rtl/usbh_report_decoder_multi_if.sv
// Report bus and decoded controller outputs of the multi-port HID report decoder.
interface usbh_report_decoder_multi_if #(
    parameter int c_ports       = 2,
    parameter int c_report_bits = 64
);
    localparam int c_port_w = (c_ports > 1) ? $clog2(c_ports) : 1;

    logic [c_report_bits-1:0] i_report;
    logic                     i_report_valid;
    logic [c_port_w-1:0]      i_report_port;
    logic [2*c_ports-1:0]     i_turbo;
    logic [8*c_ports-1:0]     o_btn;
    logic [c_ports-1:0]       o_btn_changed;
    logic [c_ports-1:0]       o_connected;

    modport master (
        output i_report, i_report_valid, i_report_port, i_turbo,
        input  o_btn, o_btn_changed, o_connected
    );

    modport slave (
        input  i_report, i_report_valid, i_report_port, i_turbo,
        output o_btn, o_btn_changed, o_connected
    );
endinterface

// File: rtl/usbh_report_decoder_multi.sv
// Multi-port HID joystick report decoder with per-port connection watchdog and change strobe.
// Optional autofire generator compiled in with USBH_REPORT_DECODER_AUTOFIRE_EN.
module usbh_report_decoder_multi #(
    parameter int c_clk_hz      = 6000000,
    parameter int c_autofire_hz = 10,
    parameter int c_ports       = 2,
    parameter int c_report_bits = 64,
    parameter int c_timeout_ms  = 100,
    parameter int c_x_msb       = 31,
    parameter int c_y_msb       = 39,
    parameter int c_a_bit       = 45,
    parameter int c_b_bit       = 44,
    parameter int c_select_bit  = 52,
    parameter int c_start_bit   = 53
) (
    input logic i_clk,
    input logic i_rst_n,
    usbh_report_decoder_multi_if.slave bus
);
    localparam int c_limit = c_clk_hz / 1000 * c_timeout_ms;
    localparam int c_cnt_w = $clog2(c_limit + 1);

    logic [7:0]           report_btn;
    logic [8*c_ports-1:0] btn_raw;
    logic [8*c_ports-1:0] btn_next;
    logic [c_ports-1:0]   btn_chg;
    logic                 unused_bits;

    // Output bit order {R,L,D,U,Start,Select,B,A}; an axis uses only its two MSBs.
    function automatic logic [7:0] decode(input logic [c_report_bits-1:0] rpt);
        logic [1:0] x;
        logic [1:0] y;
        x = rpt[c_x_msb -: 2];
        y = rpt[c_y_msb -: 2];
        decode    = '0;
        decode[0] = rpt[c_a_bit];
        decode[1] = rpt[c_b_bit];
        decode[2] = rpt[c_select_bit];
        decode[3] = rpt[c_start_bit];
        decode[4] = (y == 2'b00);
        decode[5] = (y == 2'b11);
        decode[6] = (x == 2'b00);
        decode[7] = (x == 2'b11);
    endfunction

    assign report_btn  = decode(bus.i_report);
    assign unused_bits = ^bus.i_report;

    for (genvar p = 0; p < c_ports; p++) begin : g_port
        logic             hit;
        logic [7:0]       btn_q;
        logic [c_cnt_w-1:0] wd_cnt;
        logic             conn_q;

        // Out-of-range port indices never match any generated port.
        assign hit = bus.i_report_valid && (int'(bus.i_report_port) == p);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                btn_q  <= '0;
                wd_cnt <= '0;
                conn_q <= 1'b0;
            end else if (hit) begin
                btn_q  <= report_btn;
                wd_cnt <= '0;
                conn_q <= 1'b1;
            end else if (wd_cnt != c_cnt_w'(c_limit)) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == c_cnt_w'(c_limit - 1)) begin
                    btn_q  <= '0;
                    conn_q <= 1'b0;
                end
            end
        end

        assign btn_raw[8*p +: 8]  = btn_q;
        assign bus.o_connected[p] = conn_q;
    end

`ifdef USBH_REPORT_DECODER_AUTOFIRE_EN
    localparam int c_half  = c_clk_hz / (2 * c_autofire_hz);
    localparam int c_div_w = (c_half > 1) ? $clog2(c_half) : 1;

    logic [c_div_w-1:0] div_cnt;
    logic               phase;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (div_cnt == c_div_w'(c_half - 1)) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        btn_next = btn_raw;
        for (int p = 0; p < c_ports; p++) begin
            if (bus.i_turbo[2*p])
                btn_next[8*p]     = btn_raw[8*p] & phase;
            if (bus.i_turbo[2*p+1])
                btn_next[8*p + 1] = btn_raw[8*p + 1] & phase;
        end
    end
`else
    logic unused_turbo;

    assign unused_turbo = ^bus.i_turbo;

    always_comb begin
        btn_next = btn_raw;
    end
`endif

    always_comb begin
        btn_chg = '0;
        for (int p = 0; p < c_ports; p++)
            btn_chg[p] = (btn_next[8*p +: 8] != bus.o_btn[8*p +: 8]);
    end

    // Output stage: o_btn and its change strobe are registered together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_btn         <= '0;
            bus.o_btn_changed <= '0;
        end else begin
            bus.o_btn         <= btn_next;
            bus.o_btn_changed <= btn_chg;
        end
    end
endmodule

// File: tb/tb_usbh_report_decoder_multi.sv
// Randomised bench for usbh_report_decoder_multi against an edge-count based reference model.
module tb_usbh_report_decoder_multi;
    localparam int c_clk_hz      = 1000;
    localparam int c_autofire_hz = 10;
    localparam int c_ports       = 3;
    localparam int c_report_bits = 64;
    localparam int c_timeout_ms  = 100;
    localparam int c_limit       = c_clk_hz / 1000 * c_timeout_ms;
    localparam int c_half        = c_clk_hz / (2 * c_autofire_hz);

    logic clk = 1'b0;
    logic rst_n;

    usbh_report_decoder_multi_if #(.c_ports(c_ports), .c_report_bits(c_report_bits)) bus();

    usbh_report_decoder_multi #(
        .c_clk_hz(c_clk_hz), .c_autofire_hz(c_autofire_hz), .c_ports(c_ports),
        .c_report_bits(c_report_bits), .c_timeout_ms(c_timeout_ms)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: edges since reset, edge of last accepted report per port, its decoded byte.
    int                   e;
    int                   last_e [c_ports];
    logic [7:0]           dec_last [c_ports];
    bit                   ever [c_ports];
    logic [8*c_ports-1:0] prev_btn;
    logic [2*c_ports-1:0] turbo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_dec(input logic [63:0] r);
        int x;
        int y;
        x = int'(r[31:24]);
        y = int'(r[39:32]);
        model_dec = {x >= 192, x < 64, y >= 192, y < 64, r[53], r[52], r[44], r[45]};
    endfunction

    function automatic logic [7:0] model_raw(input int p);
        model_raw = ((e - last_e[p]) >= c_limit) ? 8'h00 : dec_last[p];
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] x, input logic [7:0] y,
                                       input bit a, input bit b, input bit sel, input bit st);
        logic [63:0] r;
        r = '0;
        r[31:24] = x;
        r[39:32] = y;
        r[45] = a;
        r[44] = b;
        r[52] = sel;
        r[53] = st;
        mk = r;
    endfunction

    task automatic reset_model();
        e = 0;
        prev_btn = '0;
        for (int p = 0; p < c_ports; p++) begin
            last_e[p] = 0;
            dec_last[p] = 8'h00;
            ever[p] = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, compare 1 ns later.
    task automatic step(input bit valid, input logic [63:0] rpt, input int port);
        logic [7:0]           raw_b [c_ports];
        logic [7:0]           slice;
        bit                   ph;
        logic [8*c_ports-1:0] exp_btn;
        logic [c_ports-1:0]   exp_chg;
        logic [c_ports-1:0]   exp_conn;
        bus.i_report_valid = valid;
        bus.i_report       = rpt;
        bus.i_report_port  = 2'(port);
        bus.i_turbo        = turbo;
        for (int p = 0; p < c_ports; p++) raw_b[p] = model_raw(p);
        ph = ((e / c_half) % 2) == 1;
        @(posedge clk);
        e++;
        if (valid && port < c_ports) begin
            last_e[port]   = e;
            dec_last[port] = model_dec(rpt);
            ever[port]     = 1'b1;
        end
        for (int p = 0; p < c_ports; p++) begin
            slice = raw_b[p];
`ifdef USBH_REPORT_DECODER_AUTOFIRE_EN
            if (turbo[2*p])   slice[0] = slice[0] & ph;
            if (turbo[2*p+1]) slice[1] = slice[1] & ph;
`endif
            exp_btn[8*p +: 8] = slice;
            exp_chg[p]  = (slice != prev_btn[8*p +: 8]);
            exp_conn[p] = ever[p] && ((e - last_e[p]) < c_limit);
        end
        prev_btn = exp_btn;
        #1;
        check($sformatf("btn@%0d", e), 32'(bus.o_btn), 32'(exp_btn));
        check($sformatf("chg@%0d", e), 32'(bus.o_btn_changed), 32'(exp_chg));
        check($sformatf("conn@%0d", e), 32'(bus.o_connected), 32'(exp_conn));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [63:0] rpt_a;
        turbo = '0;
        rst_n = 1'b0;
        bus.i_report_valid = 1'b1;
        bus.i_report = {$urandom, $urandom};
        bus.i_report_port = 2'd0;
        bus.i_turbo = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_report = {$urandom, $urandom};
            bus.i_report_port = 2'($urandom_range(0, 2));
        end
        check("rst_btn", 32'(bus.o_btn), 32'h0);
        check("rst_conn", 32'(bus.o_connected), 32'h0);
        bus.i_report_valid = 1'b0;
        rst_n = 1'b1;
        reset_model();
        #1;
        check("rel_btn", 32'(bus.o_btn), 32'h0);
        check("rel_chg", 32'(bus.o_btn_changed), 32'h0);
        check("rel_conn", 32'(bus.o_connected), 32'h0);
        @(negedge clk);

        // Port 0: X=00 (L), Y=FF (D), A and Start.
        step(1'b1, mk(8'h00, 8'hFF, 1, 0, 0, 1), 0);
        step(1'b0, '0, 0);
        check("dir_btn0", 32'(bus.o_btn[7:0]), 32'h69);
        check("dir_chg0", 32'(bus.o_btn_changed[0]), 32'h1);
        check("dir_btn1", 32'(bus.o_btn[15:8]), 32'h0);
        step(1'b0, '0, 0);
        check("dir_chg0_once", 32'(bus.o_btn_changed[0]), 32'h0);

        // Back-to-back, then an out-of-range port index.
        step(1'b1, mk(8'hFF, 8'h00, 0, 1, 1, 0), 0);
        step(1'b1, mk(8'h00, 8'h00, 1, 1, 0, 0), 1);
        step(1'b1, mk(8'hFF, 8'hFF, 1, 1, 1, 1), 3);
        step(1'b0, '0, 0);
        step(1'b0, '0, 0);
        check("oob_conn2", 32'(bus.o_connected[2]), 32'h0);

        // X byte 0x80: neither L nor R.
        step(1'b1, mk(8'h80, 8'h40, 0, 0, 0, 0), 2);
        step(1'b0, '0, 0);
        check("x80_lr", 32'(bus.o_btn[23:22]), 32'h0);
        check("x80_conn", 32'(bus.o_connected[2]), 32'h1);

        // Randomised traffic including invalid port 3 and random turbo.
        for (int i = 0; i < 400; i++) begin
            if (i % 20 == 0) turbo = 6'($urandom);
            step($urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 3));
        end
        turbo = '0;

        // Watchdog expiry with no reports, then a report landing exactly on the expiry edge.
        idle(c_limit + 10);
        step(1'b1, mk(8'h40, 8'h40, 1, 0, 0, 0), 1);
        idle(c_limit - 1);
        step(1'b1, mk(8'h40, 8'h40, 0, 1, 0, 0), 1);
        check("exp_keep_conn", 32'(bus.o_connected[1]), 32'h1);
        step(1'b1, mk(8'h40, 8'h40, 1, 0, 0, 0), 0);
        idle(c_limit + 3);
        check("exp_drop_conn", 32'(bus.o_connected[0]), 32'h0);

        // Autofire on port 0 A with A and B held, refreshed before the watchdog expires.
        turbo = 6'b000001;
        rpt_a = mk(8'h40, 8'h40, 1, 1, 0, 0);
        for (int i = 0; i < 240; i++) begin
            step(i % 60 == 0, rpt_a, 0);
`ifndef USBH_REPORT_DECODER_AUTOFIRE_EN
            if (i >= 1) check("noaf_a", 32'(bus.o_btn[0]), 32'h1);
`endif
            if (i >= 1) check("af_b", 32'(bus.o_btn[1]), 32'h1);
        end
        turbo = '0;

        // Mid-report asynchronous reset discards the report.
        bus.i_report_valid = 1'b1;
        bus.i_report = mk(8'hFF, 8'hFF, 1, 1, 1, 1);
        bus.i_report_port = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_btn", 32'(bus.o_btn), 32'h0);
        check("mid_rst_conn", 32'(bus.o_connected), 32'h0);
        @(posedge clk);
        @(negedge clk);
        bus.i_report_valid = 1'b0;
        rst_n = 1'b1;
        reset_model();
        idle(3);
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1) == 0, {$urandom, $urandom}, $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/usbh_report_decoder_multi.md
# usbh_report_decoder_multi

Parametrised multi-port USB HID joystick report decoder for the USB host core clock domain. Decodes 8-bit NES-style button states for up to four controllers from HID reports tagged with a port index. Adds a per-port connection watchdog, an optional autofire generator and a change strobe. Sits between the USB host report output and the console's controller serialiser.

## Interface
Parameters:
- `c_clk_hz`, 6000000: i_clk frequency in Hz.
- `c_autofire_hz`, 10: autofire square-wave frequency.
- `c_ports`, 2: number of controller ports, 1..4.
- `c_report_bits`, 64: report width.
- `c_timeout_ms`, 100: watchdog period without a valid report before a port is dropped.
- `c_x_msb`, 31: MSB of the X-axis byte.
- `c_y_msb`, 39: MSB of the Y-axis byte.
- `c_a_bit`, 45: bit index of the A button.
- `c_b_bit`, 44: bit index of the B button.
- `c_select_bit`, 52: bit index of Select.
- `c_start_bit`, 53: bit index of Start.

Ports:
- `i_clk`  in  1  USB core clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_report`  in  c_report_bits  HID report.
- `i_report_valid`  in  1  one-cycle qualifier for i_report.
- `i_report_port`  in  max(1,$clog2(c_ports))  port the report belongs to.
- `i_turbo`  in  2*c_ports  per-port autofire enable, {B,A} per port; port p uses bits [2p+1:2p].
- `o_btn`  out  8*c_ports  per port {R,L,D,U,Start,Select,B,A}, active-high; port p is in [8p+7:8p].
- `o_btn_changed`  out  c_ports  one-cycle pulse when that port's o_btn slice changes.
- `o_connected`  out  c_ports  the port has received a report within the watchdog period.

## Operation
- **Axis decode.** Uses the two MSBs of each axis byte.
  - X: `00` sets L, `11` sets R, anything else sets neither.
  - Y: `00` sets U, `11` sets D.
  - L and R are never both set; the same holds for U and D.
- **Capture.**
  - On i_report_valid with i_report_port < c_ports, the decoded byte is written to R_btn[port].
  - A report whose port index is ≥ c_ports is ignored entirely, including by the watchdog.
- **Watchdog.**
  - Each port has a saturating counter, limit = c_clk_hz/1000*c_timeout_ms cycles.
  - A valid report for the port clears the counter and sets its connected flag.
  - When the counter reaches the limit: R_btn[port] is cleared to 0, the connected flag is cleared, and the counter holds at the limit.
  - If a valid report arrives in the same cycle as expiry, the report wins: the counter clears, R_btn loads, and the port stays connected.
- **Autofire** (only when compiled in).
  - A free-running divider toggles `phase` every c_clk_hz/(2*c_autofire_hz) cycles.
  - For port p, if i_turbo[2p] is set, the output A bit is R_btn[p].A & phase; if i_turbo[2p+1] is set, the output B bit is R_btn[p].B & phase.
  - All other bits pass through unchanged.
- **Change strobe.** o_btn_changed[p] = (new o_btn slice != previous o_btn slice), registered together with o_btn.

## Timing
- **Reset.** Asserting i_rst_n low asynchronously clears all of the following:
  - outputs: o_btn, o_btn_changed, o_connected;
  - state: R_btn, the watchdog counters, the divider and phase.
  - Mid-report reset discards that report.
- **Latency.**
  - A report with valid in cycle N updates R_btn at edge N+1.
  - o_btn updates at edge N+2, and o_btn_changed pulses for exactly the cycle after edge N+2.
  - o_connected rises at edge N+1.
- **Back-to-back reports.** Valid reports in consecutive cycles are all accepted, one per cycle, with no back-pressure. The last report for a port wins.
- **Watchdog expiry.** When expiry occurs at edge T, R_btn clears at T, o_btn clears at T+1 and o_btn_changed pulses after T+1 if the slice was nonzero.
- **Turbo toggle.** i_turbo and phase affect o_btn one cycle after the edge on which they are sampled.

## Configuration
- `USBH_REPORT_DECODER_AUTOFIRE_EN`
  - Defined: the divider, phase and the i_turbo gating above are present.
  - Undefined: the divider is not built, i_turbo is ignored (port still present), and o_btn equals the registered R_btn.

## Test plan
- Reset with i_rst_n=0 and mid-stream valid reports. After release: o_btn=0, o_btn_changed=0, o_connected=0.
- Port 0 report with X byte 0x00, Y byte 0xFF, bits 45 and 53 set. o_btn[7:0]=8'b0110_1001 two cycles after valid, o_btn_changed[0] pulses once, port 1 is unchanged.
- Interleaved back-to-back reports to port 0 then port 1 in consecutive cycles. Each slice reflects its own report and both change strobes pulse one cycle apart. A report with port index 3 when c_ports=2 changes nothing.
- No reports for c_timeout_ms after connecting with A held. o_connected drops and o_btn slice goes to 0 at limit+1 with one change pulse. A report on the expiry cycle keeps the port connected.
- Autofire built in, c_clk_hz=1000, c_autofire_hz=10, i_turbo[0]=1, A held. o_btn A bit toggles every 50 cycles and B is steady. With the macro undefined, A stays 1.
- X byte 0x80 (MSBs `10`). Neither L nor R is set.
